// File: rtl/td4_pkg.sv
// Shared TD4 definitions: opcode encodings, default widths and the selector code map.
package td4_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned PC_W_DEF   = 4;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // Selector code is {sel_b, sel_a}.
  typedef enum logic [1:0] {
    SelA    = 2'b00,
    SelB    = 2'b01,
    SelIn   = 2'b10,
    SelZero = 2'b11
  } sel_code_e;

endpackage

// File: rtl/td4_decoder.sv
// Combinational TD4 opcode decode: selector controls and register load strobes.
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] op,
  input  logic       c,
  output logic       sel_a,
  output logic       sel_b,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc
);

  always_comb begin
    sel_a  = op[0] | op[3];
    sel_b  = op[1];
    ld_a   = ~op[3] & ~op[2];
    ld_b   = ~op[3] &  op[2];
    ld_out =  op[3] & ~op[2];
    // op[0] distinguishes JMP (unconditional) from JNC (taken only when carry clear).
    ld_pc  =  op[3] &  op[2] & (op[0] | ~c);
  end

endmodule

// File: rtl/register_writeback.sv
// TD4 write-back: decodes the opcode and retires the ALU sum into A, B, OUT or PC.
module register_writeback
  import td4_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              IN_CE,
  input  logic [3:0]        IN_OP,
  input  logic [DATA_W-1:0] IN_SUM,
  input  logic              IN_CARRY,
  output logic              OUT_SEL_A,
  output logic              OUT_SEL_B,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic [PC_W-1:0]   OUT_PC,
  output logic              OUT_C
);

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [PC_W-1:0]   pc_q, pc_d, jmp_tgt;
  logic              c_q, c_d;
  logic              ld_a, ld_b, ld_out, ld_pc;

  td4_decoder u_decoder (
    .op     (IN_OP),
    .c      (c_q),
    .sel_a  (OUT_SEL_A),
    .sel_b  (OUT_SEL_B),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .ld_out (ld_out),
    .ld_pc  (ld_pc)
  );

  // Jump target: truncate a wide sum, zero-extend a narrow one.
  if (PC_W <= DATA_W) begin : g_pc_trunc
    assign jmp_tgt = IN_SUM[PC_W-1:0];
  end else begin : g_pc_zext
    assign jmp_tgt = {{(PC_W-DATA_W){1'b0}}, IN_SUM};
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    if (IN_CE) begin
      if (ld_a)   a_d   = IN_SUM;
      if (ld_b)   b_d   = IN_SUM;
      if (ld_out) out_d = IN_SUM;
      pc_d = ld_pc ? jmp_tgt : pc_q + 1'b1;
      c_d  = IN_CARRY;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= PC_W'(RESET_PC);
      c_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
    end
  end

  assign OUT_A    = a_q;
  assign OUT_B    = b_q;
  assign OUT_PORT = out_q;
  assign OUT_PC   = pc_q;
  assign OUT_C    = c_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with hand-computed expectations.
module tb_register_writeback;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [3:0] op;
  logic [3:0] sum;
  logic       carry;
  logic       sel_a, sel_b;
  logic [3:0] a, b, port, pc;
  logic       c;

  int n_cmp = 0;
  int n_err = 0;

  // {sel_a, sel_b, ld_a, ld_b, ld_out, jmp_if_nc, jmp_always}, indexed by opcode.
  localparam logic [6:0] REF_TBL [16] = '{
    7'b0010000, 7'b1010000, 7'b0110000, 7'b1110000,
    7'b0001000, 7'b1001000, 7'b0101000, 7'b1101000,
    7'b1000100, 7'b1000100, 7'b1100100, 7'b1100100,
    7'b1000010, 7'b1000001, 7'b1100010, 7'b1100001
  };

  register_writeback dut (
    .I_CLK     (clk),
    .I_RST_N   (rst_n),
    .IN_CE     (ce),
    .IN_OP     (op),
    .IN_SUM    (sum),
    .IN_CARRY  (carry),
    .OUT_SEL_A (sel_a),
    .OUT_SEL_B (sel_b),
    .OUT_A     (a),
    .OUT_B     (b),
    .OUT_PORT  (port),
    .OUT_PC    (pc),
    .OUT_C     (c)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [3:0] eo, input logic [3:0] ep, input logic ec);
    check_eq({tag, ".a"},   32'(a),    32'(ea));
    check_eq({tag, ".b"},   32'(b),    32'(eb));
    check_eq({tag, ".out"}, 32'(port), 32'(eo));
    check_eq({tag, ".pc"},  32'(pc),   32'(ep));
    check_eq({tag, ".c"},   32'(c),    32'(ec));
  endtask

  initial begin
    logic [3:0] ma, mb, mo, mp, s;
    logic       mc;
    logic [6:0] r;

    rst_n = 1'b0; ce = 1'b0; op = 4'h0; sum = 4'h0; carry = 1'b0;
    repeat (2) step();
    check_regs("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;

    // Load something, then assert reset between edges.
    ce = 1'b1; op = 4'b0011; sum = 4'h7; carry = 1'b1;
    step();
    check_regs("pre_reset", 4'h7, 4'h0, 4'h0, 4'h1, 1'b1);
    #200 rst_n = 1'b0;
    #1;
    check_regs("async_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    rst_n = 1'b1;

    sum = 4'h0; carry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq($sformatf("pc_count%0d", i), 32'(pc), 32'((i + 1) % 16));
    end

    // Loads
    op = 4'b0011; sum = 4'h7; step();
    check_regs("ld_a", 4'h7, 4'h0, 4'h0, 4'h1, 1'b0);
    op = 4'b0111; sum = 4'h3; step();
    check_regs("ld_b", 4'h7, 4'h3, 4'h0, 4'h2, 1'b0);
    op = 4'b1011; sum = 4'h5; step();
    check_regs("ld_out", 4'h7, 4'h3, 4'h5, 4'h3, 1'b0);

    // Carry: JNC after a carrying ADD falls through
    op = 4'b0000; sum = 4'h2; carry = 1'b1; step();
    check_regs("add_carry", 4'h2, 4'h3, 4'h5, 4'h4, 1'b1);
    op = 4'b1110; sum = 4'h9; carry = 1'b0; step();
    check_regs("jnc_not_taken", 4'h2, 4'h3, 4'h5, 4'h5, 1'b0);

    // Jumps
    op = 4'b1110; sum = 4'h9; carry = 1'b0; step();
    check_regs("jnc_taken", 4'h2, 4'h3, 4'h5, 4'h9, 1'b0);
    op = 4'b1111; sum = 4'h4; carry = 1'b0; step();
    check_regs("jmp", 4'h2, 4'h3, 4'h5, 4'h4, 1'b0);

    // Hold
    ce = 1'b0; op = 4'b0000; sum = 4'hF; carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_regs($sformatf("hold%0d", i), 4'h2, 4'h3, 4'h5, 4'h4, 1'b0);
      check_eq($sformatf("hold%0d.sel_a", i), 32'(sel_a), 32'(0));
      check_eq($sformatf("hold%0d.sel_b", i), 32'(sel_b), 32'(0));
    end

    // Decode sweep: prime C, check selector, then retire the opcode against the table.
    ce = 1'b1;
    ma = 4'h2; mb = 4'h3; mo = 4'h5; mp = 4'h4; mc = 1'b0;
    for (int cv = 0; cv < 2; cv++) begin
      for (int k = 0; k < 16; k++) begin
        op = 4'b0011; sum = 4'h0; carry = cv[0];
        step();
        ma = 4'h0; mp = mp + 4'h1; mc = cv[0];
        op = k[3:0];
        #1;
        r = REF_TBL[k];
        check_eq($sformatf("sel_a op%0h c%0d", k, cv), 32'(sel_a), 32'(r[6]));
        check_eq($sformatf("sel_b op%0h c%0d", k, cv), 32'(sel_b), 32'(r[5]));
        s = k[3:0] ^ 4'h5;
        sum = s; carry = ~cv[0];
        step();
        if (r[4]) ma = s;
        if (r[3]) mb = s;
        if (r[2]) mo = s;
        mp = (r[0] || (r[1] && !mc)) ? s : mp + 4'h1;
        mc = ~cv[0];
        check_regs($sformatf("exec op%0h c%0d", k, cv), ma, mb, mo, mp, mc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
